edge_event_capture: RTL and testbench
=====================================

EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning width of the edge vector.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning event queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter TS_W, default 16, meaning timestamp width.
REQ-004 The block SHALL have the following ports, one per line, with clock and reset first:
  clk  input  1  single clock; all logic on its rising edge
  reset  input  1  asynchronous, active-high reset
  edge_in  input  W  per-bit single-cycle edge pulses from the upstream edge detector
  evt_valid  output  1  queue head holds an event
  evt_ready  input  1  consumer accepts the head
  evt_bits  output  W  edge vector of the head event
  evt_ts  output  TS_W  timestamp of the head event
  level  output  $clog2(DEPTH)+1  current occupancy
  overflow  output  1  sticky flag: an event was dropped
  drop_cnt  output  8  saturating count of dropped events
  ovf_clr  input  1  single-cycle clear of overflow and drop_cnt

Function
REQ-005 The block SHALL maintain a free-running TS_W-bit counter that increments every cycle after reset and wraps from all-ones to 0.
REQ-006 Push: a cycle with edge_in != 0 SHALL enqueue {ts, edge_in}; edge_in == 0 SHALL never enqueue.
REQ-007 Pop: a cycle with evt_valid && evt_ready SHALL dequeue the head.
REQ-008 Latency: a push into an empty queue SHALL raise evt_valid on the next cycle; there is no combinational fall-through.
REQ-009 Ordering SHALL be strict FIFO; evt_bits and evt_ts SHALL hold stable while evt_valid && !evt_ready.
REQ-010 Full with push and no pop: the event SHALL be dropped, overflow SHALL set, and drop_cnt SHALL increment, saturating at 255.
REQ-011 Full with push and pop in the same cycle: the push SHALL be accepted, level SHALL stay at DEPTH, and no drop SHALL occur.
REQ-012 Empty with pop attempt: no effect; evt_valid stays 0 and level stays 0.
REQ-013 level SHALL update on the cycle after a push or pop, and SHALL be unchanged on a simultaneous push and pop.
REQ-014 ovf_clr SHALL clear overflow and drop_cnt on the next cycle.
REQ-015 ovf_clr coincident with a drop: the drop SHALL win, leaving overflow=1 and drop_cnt=1.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-017 Asserting reset SHALL immediately force evt_valid=0, level=0, overflow=0, drop_cnt=0 and ts=0, and SHALL empty the queue.
REQ-018 Reset mid-operation SHALL discard all queued events; the first push after release SHALL carry ts equal to the number of cycles since release, starting from 0.
REQ-019 evt_bits and evt_ts SHALL read 0 while evt_valid=0 after reset.

Configuration
REQ-020 With macro EDGE_CAPTURE_TS_EN defined, the timestamp counter and the TS_W bits per queue entry SHALL be present, and evt_ts SHALL carry the captured timestamp.
REQ-021 Without EDGE_CAPTURE_TS_EN, the counter SHALL be omitted, queue entries SHALL be W bits wide, and evt_ts SHALL be tied to 0; all other behaviour SHALL be unchanged.

Structure
REQ-022 Package edge_capture_pkg SHALL hold the default constants (W, DEPTH, TS_W, DROP_CNT_W=8) and the event struct typedef {ts, bits}.
REQ-023 Queue storage and pointers SHALL be a single sub-module, edge_evt_fifo; capture logic, timestamp counter and overflow logic SHALL stay in the top module.

Verification
REQ-024 Scenario 1: edge_in=32'h0000_0001 for one cycle at ts=5, with evt_ready=0 -> next cycle evt_valid=1, evt_bits=32'h1, evt_ts=5, level=1.
REQ-025 Scenario 2: 9 consecutive non-zero pushes with DEPTH=8 and evt_ready=0 -> level=8, overflow=1, drop_cnt=1; pops return the first 8 vectors in order.
REQ-026 Scenario 3: queue full, push 32'hA5 with evt_ready=1 in the same cycle -> no drop, level stays 8, and 32'hA5 is the last word popped.
REQ-027 Scenario 4: 300 drops followed by ovf_clr, plus ovf_clr coincident with a drop -> drop_cnt saturates at 255 then clears to 0; in the coincident case overflow=1 and drop_cnt=1.
REQ-028 Scenario 5: reset asserted with level=5 -> evt_valid=0 and level=0 immediately; a push 3 cycles after release carries evt_ts=3.
REQ-029 Scenario 6: edge_in=0 for 100 cycles, with EDGE_CAPTURE_TS_EN undefined and one push of 32'hFFFF_FFFF -> a single event with evt_ts=0.

Source files
------------

// File: rtl/edge_capture_pkg.sv
// Shared constants, event type and helpers for the edge event capture block.
package edge_capture_pkg;

    localparam int W_DEF      = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int TS_W_DEF   = 16;
    localparam int DROP_CNT_W = 8;

    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic [W_DEF-1:0]    bits;
    } evt_t;

    // Holds at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(
        input logic [DROP_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/edge_evt_fifo.sv
// Event queue storage with extra-bit pointers; head output is masked to 0
// whenever the queue is empty.
import edge_capture_pkg::*;

module edge_evt_fifo #(
    parameter int DW    = 48,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a full queue can
    // still take a push when it is also being read.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign valid = !empty;
    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign level = wptr_q - rptr_q;

endmodule

// File: rtl/edge_event_capture.sv
// Queues non-zero edge vectors with optional timestamps and tracks drops.
// Define EDGE_CAPTURE_TS_EN to include the timestamp counter and evt_ts.
import edge_capture_pkg::*;

module edge_event_capture #(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [W-1:0]               edge_in,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [W-1:0]               evt_bits,
    output logic [TS_W-1:0]            evt_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_cnt,
    input  logic                       ovf_clr
);

`ifdef EDGE_CAPTURE_TS_EN
    localparam int DW = TS_W + W;
`else
    localparam int DW = W;
`endif

    logic                  push_req;
    logic                  pop_req;
    logic                  full;
    logic                  drop;
    logic [DW-1:0]         wdata;
    logic [DW-1:0]         rdata;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    assign push_req = |edge_in;
    assign pop_req  = evt_valid && evt_ready;
    assign drop     = push_req && full && !pop_req;

`ifdef EDGE_CAPTURE_TS_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end

    assign wdata    = {ts_q, edge_in};
    assign evt_bits = rdata[W-1:0];
    assign evt_ts   = rdata[DW-1 -: TS_W];
`else
    assign wdata    = edge_in;
    assign evt_bits = rdata;
    assign evt_ts   = '0;
`endif

    edge_evt_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (wdata),
        .pop   (evt_ready),
        .rdata (rdata),
        .valid (evt_valid),
        .full  (full),
        .level (level)
    );

    // Clear is applied first so a coincident drop still lands.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc(drop_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign overflow = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed self-checking bench for edge_event_capture (default parameters).
`timescale 1ns/1ps

module tb_edge_event_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] edge_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_bits;
    logic [15:0] evt_ts;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] cyc;
    logic [31:0] vec [8];
    logic [15:0] tsv [8];

    always #5 clk = ~clk;

    edge_event_capture dut (
        .clk       (clk),
        .reset     (reset),
        .edge_in   (edge_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_bits  (evt_bits),
        .evt_ts    (evt_ts),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .ovf_clr   (ovf_clr)
    );

    function automatic logic [15:0] exp_ts(input logic [15:0] t);
`ifdef EDGE_CAPTURE_TS_EN
        return t;
`else
        return 16'h0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset     = 1'b1;
        edge_in   = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        cyc       = '0;
        step();
        step();
        check("rst_valid", evt_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_bits", evt_bits, 0);
        check("rst_ts", evt_ts, 0);
        reset = 1'b0;
        cyc   = '0;

        // Scenario 1: single push sampled while ts == 5
        repeat (5) step();
        check("s1_pre_valid", evt_valid, 0);
        edge_in = 32'h1;
        step();
        edge_in = '0;
        check("s1_valid", evt_valid, 1);
        check("s1_bits", evt_bits, 32'h1);
        check("s1_ts", evt_ts, exp_ts(16'd5));
        check("s1_level", level, 1);
        step();
        check("s1_hold_bits", evt_bits, 32'h1);
        check("s1_hold_ts", evt_ts, exp_ts(16'd5));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("s1_pop_valid", evt_valid, 0);
        check("s1_pop_level", level, 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("empty_pop_level", level, 0);
        check("empty_pop_valid", evt_valid, 0);

        // Scenario 2: nine pushes into an eight-deep queue
        for (int i = 0; i < 9; i++) begin
            edge_in = 32'h10 + 32'(i);
            if (i < 8) begin
                vec[i] = edge_in;
                tsv[i] = cyc;
            end
            step();
            if (i == 7) check("s2_level8_no_ovf", overflow, 0);
        end
        edge_in = '0;
        check("s2_level", level, 8);
        check("s2_ovf", overflow, 1);
        check("s2_drop", drop_cnt, 1);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("s2_pop_bits", evt_bits, vec[i]);
            check("s2_pop_ts", evt_ts, exp_ts(tsv[i]));
            step();
        end
        evt_ready = 1'b0;
        check("s2_drained", evt_valid, 0);
        check("s2_level0", level, 0);

        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_drop", drop_cnt, 0);

        // Scenario 3: push while full with concurrent pop
        for (int i = 0; i < 8; i++) begin
            edge_in = 32'h100 + 32'(i);
            step();
        end
        check("s3_full_level", level, 8);
        edge_in   = 32'hA5;
        evt_ready = 1'b1;
        step();
        edge_in = '0;
        check("s3_level", level, 8);
        check("s3_ovf", overflow, 0);
        check("s3_drop", drop_cnt, 0);
        for (int i = 1; i < 8; i++) begin
            check("s3_pop_bits", evt_bits, 32'h100 + 32'(i));
            step();
        end
        check("s3_last", evt_bits, 32'hA5);
        step();
        evt_ready = 1'b0;
        check("s3_empty", evt_valid, 0);

        // Scenario 4: saturation, clear, clear coincident with drop
        for (int i = 0; i < 8; i++) begin
            edge_in = 32'h200 + 32'(i);
            step();
        end
        for (int i = 0; i < 300; i++) begin
            edge_in = 32'h3;
            step();
            if (i == 253) check("s4_drop254", drop_cnt, 254);
            if (i == 254) check("s4_drop255", drop_cnt, 255);
        end
        edge_in = '0;
        check("s4_sat", drop_cnt, 255);
        check("s4_ovf", overflow, 1);
        check("s4_level", level, 8);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("s4_clr_drop", drop_cnt, 0);
        check("s4_clr_ovf", overflow, 0);
        ovf_clr = 1'b1;
        edge_in = 32'h4;
        step();
        ovf_clr = 1'b0;
        edge_in = '0;
        check("s4_coinc_ovf", overflow, 1);
        check("s4_coinc_drop", drop_cnt, 1);
        check("s4_head", evt_bits, 32'h200);

        // Scenario 5: reset mid-operation with five queued
        evt_ready = 1'b1;
        repeat (3) step();
        evt_ready = 1'b0;
        check("s5_level5", level, 5);
        reset = 1'b1;
        #1;
        check("s5_rst_valid", evt_valid, 0);
        check("s5_rst_level", level, 0);
        check("s5_rst_ovf", overflow, 0);
        check("s5_rst_drop", drop_cnt, 0);
        check("s5_rst_bits", evt_bits, 0);
        step();
        reset = 1'b0;
        cyc   = '0;
        repeat (3) step();
        edge_in = 32'h77;
        step();
        edge_in = '0;
        check("s5_valid", evt_valid, 1);
        check("s5_bits", evt_bits, 32'h77);
        check("s5_ts", evt_ts, exp_ts(16'd3));
        check("s5_level", level, 1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;

        // Scenario 6: long idle then one all-ones push
        repeat (100) step();
        check("s6_idle_valid", evt_valid, 0);
        check("s6_idle_level", level, 0);
        tsv[0]  = cyc;
        edge_in = 32'hFFFF_FFFF;
        step();
        edge_in = '0;
        check("s6_bits", evt_bits, 32'hFFFF_FFFF);
        check("s6_ts", evt_ts, exp_ts(tsv[0]));
        check("s6_level", level, 1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("s6_single", evt_valid, 0);
        check("s6_level0", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
